bcd_calc_sequencer: RTL and testbench
=====================================

BCD_CALC_SEQUENCER -- requirements
Module: bcd_calc_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 2, cycles dp_a/dp_b/dp_op are held stable before dp_result is sampled (legal range 1..15).
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: digit_in  in  4  BCD key digit.
REQ-005 SHALL have port: digit_valid  in  1  one-cycle strobe qualifying digit_in.
REQ-006 SHALL have port: op_in  in  1  operator key (0 add, 1 subtract).
REQ-007 SHALL have port: op_valid  in  1  one-cycle strobe qualifying op_in.
REQ-008 SHALL have port: eq_valid  in  1  one-cycle "=" strobe.
REQ-009 SHALL have port: clr  in  1  one-cycle synchronous clear strobe.
REQ-010 SHALL have port: dp_a  out  8  operand A to the 2-digit BCD add/sub datapath ({tens,ones}).
REQ-011 SHALL have port: dp_b  out  8  operand B to the datapath ({tens,ones}).
REQ-012 SHALL have port: dp_op  out  1  operator to the datapath.
REQ-013 SHALL have port: dp_result  in  8  datapath BCD result ({tens,ones}).
REQ-014 SHALL have port: dp_flag  in  1  datapath overflow-or-underflow.
REQ-015 SHALL have port: result  out  8  registered BCD result.
REQ-016 SHALL have port: result_valid  out  1  high while result is valid.
REQ-017 SHALL have port: err  out  1  high while in ERR.
REQ-018 SHALL have port: busy  out  1  high while in WAIT.
REQ-019 SHALL have port: state  out  3  encoding ENTER_A=0, ENTER_B=1, WAIT=2, DONE=3, ERR=4.

Function
REQ-020 SHALL implement a Moore FSM with states ENTER_A, ENTER_B, WAIT, DONE and ERR; all outputs registered.
REQ-021 SHALL, on an accepted digit, shift the active operand: operand <= {operand[3:0], digit_in}; the old tens digit is discarded.
REQ-022 SHALL ignore digit_valid when digit_in > 9, with no state or register change.
REQ-023 SHALL apply digits to A in ENTER_A and to B in ENTER_B; SHALL ignore digits in WAIT.
REQ-024 SHALL, on op_valid in ENTER_A, latch dp_op <= op_in, clear B to 8'h00 and go to ENTER_B.
REQ-025 SHALL, on op_valid in ENTER_B, overwrite dp_op and stay in ENTER_B with B unchanged.
REQ-026 SHALL, on eq_valid in ENTER_B, go to WAIT and load the settle counter with SETTLE_CYCLES; eq_valid in any other state is ignored.
REQ-027 SHALL, in WAIT, decrement the counter each cycle, and on the cycle the counter reaches 0 sample dp_result and dp_flag. Latency from eq_valid to result_valid/err high is SETTLE_CYCLES+1 cycles.
REQ-028 SHALL, if the sampled dp_flag=0, load result <= dp_result, set result_valid=1 and go to DONE.
REQ-029 SHALL, if the sampled dp_flag=1, load result <= 8'h00, set err=1 and go to ERR.
REQ-030 SHALL hold dp_a, dp_b and dp_op constant throughout WAIT.
REQ-031 SHALL ignore op_valid, eq_valid and digit_valid while in WAIT; only clr or rst can abort WAIT.
REQ-032 SHALL, on a valid digit in DONE or ERR, clear A, B, result, result_valid and err, shift the digit into A, and go to ENTER_A in the same cycle.
REQ-033 SHALL, on clr in any state, set A=B=result=8'h00, dp_op=0, result_valid=0 and err=0, and go to ENTER_A.
REQ-034 SHALL resolve simultaneous strobes by priority: clr > eq_valid > op_valid > digit_valid; lower-priority strobes in that cycle are dropped.
REQ-035 SHALL drive busy=1 exactly while state==WAIT.

Reset
REQ-036 SHALL, while rst=1, asynchronously force state=ENTER_A, dp_a=dp_b=result=8'h00, dp_op=0, result_valid=0, err=0, busy=0 and settle counter=0, including when rst asserts mid-WAIT.

Configuration
REQ-037 SHALL, with ACCUM_CHAIN_EN defined, treat op_valid in DONE as a chain: A <= result, dp_op <= op_in, B <= 8'h00, result_valid <= 0, next state ENTER_B.
REQ-038 SHALL, without ACCUM_CHAIN_EN, ignore op_valid in DONE.

Verification
REQ-039 SHALL cover: digits 4,7, op add, digits 2,5, eq, datapath returns 8'h72 flag 0 -> dp_a=8'h47, dp_b=8'h25, result=8'h72 and result_valid high exactly 3 cycles after eq (SETTLE_CYCLES=2).
REQ-040 SHALL cover: A=8'h12, subtract, B=8'h30, datapath flag=1 -> err=1, result=8'h00, state=ERR; a following digit 5 -> ENTER_A with A=8'h05.
REQ-041 SHALL cover: digits 1,2,3 -> A=8'h23; digit_in=4'hC -> A unchanged.
REQ-042 SHALL cover: clr together with eq in ENTER_B -> ENTER_A with all registers zero and no WAIT entered.
REQ-043 SHALL cover: rst asserted during WAIT -> outputs at reset values immediately without waiting for a clock edge; busy=0.
REQ-044 SHALL cover: with ACCUM_CHAIN_EN, DONE with result=8'h72, op subtract -> dp_a=8'h72, dp_op=1, state=ENTER_B; without the macro -> state remains DONE.

Source files
------------

// File: rtl/bcd_calc_sequencer.sv
// Key-entry sequencer for a 2-digit BCD add/sub calculator driving an external datapath.
// Optional macro ACCUM_CHAIN_EN: an operator key in DONE chains the result into operand A.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ENTER_A | collecting digits into operand A
// ENTER_B | operator latched, collecting digits into operand B
// WAIT    | operands held on the datapath, settle counter running
// DONE    | result registered and valid
// ERR     | datapath flagged overflow/underflow, result forced to zero
module bcd_calc_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       op_in,
  input  logic       op_valid,
  input  logic       eq_valid,
  input  logic       clr,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  output logic       dp_op,
  input  logic [7:0] dp_result,
  input  logic       dp_flag,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        op_q, op_d;
  logic [7:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        digit_ok;

  assign digit_ok = digit_valid && (digit_in <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ENTER_A;
      a_q            <= 8'h00;
      b_q            <= 8'h00;
      op_q           <= 1'b0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      cnt_q          <= 4'd0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
    end
  end

  // Strobes are resolved strictly by priority: the highest asserted one owns the cycle,
  // even if that state ignores it.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (clr) begin
      state_d  = ENTER_A;
      a_d      = 8'h00;
      b_d      = 8'h00;
      op_d     = 1'b0;
      result_d = 8'h00;
      cnt_d    = 4'd0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (eq_valid) begin
            state_d = ENTER_A;
          end else if (op_valid) begin
            op_d    = op_in;
            b_d     = 8'h00;
            state_d = ENTER_B;
          end else if (digit_ok) begin
            a_d = {a_q[3:0], digit_in};
          end
        end
        ENTER_B: begin
          if (eq_valid) begin
            cnt_d   = 4'(SETTLE_CYCLES);
            state_d = WAIT;
          end else if (op_valid) begin
            op_d = op_in;
          end else if (digit_ok) begin
            b_d = {b_q[3:0], digit_in};
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            if (dp_flag) begin
              result_d = 8'h00;
              state_d  = ERR;
            end else begin
              result_d = dp_result;
              state_d  = DONE;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE, ERR: begin
          if (eq_valid) begin
            state_d = state_q;
          end else if (op_valid) begin
`ifdef ACCUM_CHAIN_EN
            if (state_q == DONE) begin
              a_d     = result_q;
              op_d    = op_in;
              b_d     = 8'h00;
              state_d = ENTER_B;
            end
`else
            state_d = state_q;
`endif
          end else if (digit_ok) begin
            a_d      = {4'h0, digit_in};
            b_d      = 8'h00;
            result_d = 8'h00;
            state_d  = ENTER_A;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
    result_valid_d = (state_d == DONE);
    err_d          = (state_d == ERR);
    busy_d         = (state_d == WAIT);
  end

  always_comb begin
    dp_a         = a_q;
    dp_b         = b_q;
    dp_op        = op_q;
    result       = result_q;
    result_valid = result_valid_q;
    err          = err_q;
    busy         = busy_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Directed self-checking bench for bcd_calc_sequencer (SETTLE_CYCLES=2).
module tb_bcd_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       op_in;
  logic       op_valid;
  logic       eq_valid;
  logic       clr;
  logic [7:0] dp_a, dp_b;
  logic       dp_op;
  logic [7:0] dp_result;
  logic       dp_flag;
  logic [7:0] result;
  logic       result_valid, err, busy;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  bcd_calc_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .op_in(op_in), .op_valid(op_valid), .eq_valid(eq_valid), .clr(clr),
    .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_result(dp_result), .dp_flag(dp_flag),
    .result(result), .result_valid(result_valid), .err(err), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic key_digit(input logic [3:0] d);
    @(negedge clk); digit_in = d; digit_valid = 1'b1;
    @(negedge clk); digit_valid = 1'b0;
  endtask

  task automatic key_op(input logic o);
    @(negedge clk); op_in = o; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic key_eq();
    @(negedge clk); eq_valid = 1'b1;
    @(negedge clk); eq_valid = 1'b0;
  endtask

  task automatic key_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({dp_a, dp_b, result} !== 24'h0) begin failures++; $display("FAIL reset_regs got=%h exp=000000", {dp_a, dp_b, result}); end
    checks++; if ({dp_op, result_valid, err, busy} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {dp_op, result_valid, err, busy}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    key_clr();
    key_digit(4); key_digit(7);
    key_op(1'b0);
    key_digit(2); key_digit(5);
    dp_result = 8'h72; dp_flag = 1'b0;
    key_eq();
    checks++; if (busy !== 1'b1 || state !== 3'd2) begin failures++; $display("FAIL add_wait got=busy%b/st%0d exp=busy1/st2", busy, state); end
    cyc = 0;
    while (!result_valid && cyc < 20) begin
      @(negedge clk); cyc++;
      if (cyc < 3) begin
        checks++; if (dp_a !== 8'h47 || dp_b !== 8'h25 || dp_op !== 1'b0) begin failures++; $display("FAIL add_hold got=%h/%h/%b exp=47/25/0", dp_a, dp_b, dp_op); end
      end
    end
    checks++; if (cyc !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", cyc); end
    checks++; if (result !== 8'h72 || state !== 3'd3 || busy !== 1'b0) begin failures++; $display("FAIL add_result got=%h/st%0d/busy%b exp=72/st3/busy0", result, state, busy); end
    checks++; if (dp_a !== 8'h47 || dp_b !== 8'h25) begin failures++; $display("FAIL add_operands got=%h/%h exp=47/25", dp_a, dp_b); end
  endtask

  task automatic test_wait_ignore();
    int cyc;
    key_clr();
    key_digit(3);
    key_op(1'b1);
    key_digit(1);
    dp_result = 8'h02; dp_flag = 1'b0;
    key_eq();
    digit_in = 4'd9; digit_valid = 1'b1; op_in = 1'b0; op_valid = 1'b1; eq_valid = 1'b1;
    @(negedge clk); digit_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0;
    checks++; if (dp_a !== 8'h03 || dp_b !== 8'h01 || dp_op !== 1'b1 || state !== 3'd2) begin failures++; $display("FAIL wait_ignore got=%h/%h/%b/st%0d exp=03/01/1/st2", dp_a, dp_b, dp_op, state); end
    cyc = 1;
    while (!result_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 3 || result !== 8'h02) begin failures++; $display("FAIL wait_latency got=%0d/%h exp=3/02", cyc, result); end
  endtask

  task automatic test_sub_err();
    int cyc;
    key_clr();
    key_digit(1); key_digit(2);
    key_op(1'b1);
    key_digit(3); key_digit(0);
    checks++; if (dp_a !== 8'h12 || dp_b !== 8'h30 || dp_op !== 1'b1) begin failures++; $display("FAIL sub_operands got=%h/%h/%b exp=12/30/1", dp_a, dp_b, dp_op); end
    dp_result = 8'h82; dp_flag = 1'b1;
    key_eq();
    cyc = 0;
    while (!err && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 3) begin failures++; $display("FAIL err_latency got=%0d exp=3", cyc); end
    checks++; if (result !== 8'h00 || state !== 3'd4 || result_valid !== 1'b0) begin failures++; $display("FAIL err_state got=%h/st%0d/rv%b exp=00/st4/rv0", result, state, result_valid); end
    key_digit(5);
    checks++; if (state !== 3'd0 || dp_a !== 8'h05 || dp_b !== 8'h00 || err !== 1'b0) begin failures++; $display("FAIL err_restart got=st%0d/%h/%h/err%b exp=st0/05/00/err0", state, dp_a, dp_b, err); end
    dp_flag = 1'b0;
  endtask

  task automatic test_digits();
    key_clr();
    key_digit(1); key_digit(2); key_digit(3);
    checks++; if (dp_a !== 8'h23) begin failures++; $display("FAIL digit_shift got=%h exp=23", dp_a); end
    key_digit(4'hC);
    checks++; if (dp_a !== 8'h23 || state !== 3'd0) begin failures++; $display("FAIL digit_invalid got=%h/st%0d exp=23/st0", dp_a, state); end
    key_op(1'b0);
    key_digit(8);
    key_op(1'b1);
    checks++; if (dp_op !== 1'b1 || dp_b !== 8'h08 || state !== 3'd1 || dp_a !== 8'h23) begin failures++; $display("FAIL op_overwrite got=%b/%h/st%0d/%h exp=1/08/st1/23", dp_op, dp_b, state, dp_a); end
  endtask

  task automatic test_clr_priority();
    key_clr();
    key_digit(4);
    key_op(1'b1);
    key_digit(6);
    @(negedge clk); clr = 1'b1; eq_valid = 1'b1;
    @(negedge clk); clr = 1'b0; eq_valid = 1'b0;
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL clr_eq_state got=st%0d/busy%b exp=st0/busy0", state, busy); end
    checks++; if ({dp_a, dp_b, result, dp_op} !== 25'h0) begin failures++; $display("FAIL clr_eq_regs got=%h/%h/%h/%b exp=00/00/00/0", dp_a, dp_b, result, dp_op); end
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL clr_eq_nowait got=st%0d exp=st0", state); end
  endtask

  task automatic test_rst_wait();
    key_clr();
    key_digit(9);
    key_op(1'b1);
    key_digit(1);
    key_eq();
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_wait_state got=st%0d/busy%b exp=st0/busy0", state, busy); end
    checks++; if ({dp_a, dp_b, result, dp_op, result_valid, err} !== 27'h0) begin failures++; $display("FAIL rst_wait_regs got=%h/%h/%h exp=00/00/00", dp_a, dp_b, result); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (state !== 3'd0 || result_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_after got=st%0d/rv%b exp=st0/rv0", state, result_valid); end
  endtask

  task automatic test_chain();
    int cyc;
    key_clr();
    key_digit(4); key_digit(7);
    key_op(1'b0);
    key_digit(2); key_digit(5);
    dp_result = 8'h72; dp_flag = 1'b0;
    key_eq();
    cyc = 0;
    while (!result_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (result !== 8'h72 || state !== 3'd3) begin failures++; $display("FAIL chain_setup got=%h/st%0d exp=72/st3", result, state); end
    key_eq();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL done_eq_ignore got=st%0d exp=st3", state); end
    key_op(1'b1);
`ifdef ACCUM_CHAIN_EN
    checks++; if (state !== 3'd1 || dp_a !== 8'h72 || dp_op !== 1'b1 || dp_b !== 8'h00 || result_valid !== 1'b0) begin failures++; $display("FAIL chain_op got=st%0d/%h/%b/%h/rv%b exp=st1/72/1/00/rv0", state, dp_a, dp_op, dp_b, result_valid); end
`else
    checks++; if (state !== 3'd3 || dp_a !== 8'h47 || dp_op !== 1'b0 || result_valid !== 1'b1) begin failures++; $display("FAIL chain_ignored got=st%0d/%h/%b/rv%b exp=st3/47/0/rv1", state, dp_a, dp_op, result_valid); end
`endif
  endtask

  initial begin
    digit_in = 4'd0; digit_valid = 1'b0; op_in = 1'b0; op_valid = 1'b0;
    eq_valid = 1'b0; clr = 1'b0; dp_result = 8'h00; dp_flag = 1'b0; rst = 1'b0;
    test_reset();
    test_add();
    test_wait_ignore();
    test_sub_err();
    test_digits();
    test_clr_priority();
    test_rst_wait();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
